// File: rtl/shift_pkg.sv
// shift_pkg
// Shared definitions for the shift sequencer. It holds the six shift ALUop
// encodings, the controller state enum, and the decode helpers that classify
// an ALUop and turn the requested amount into an effective shift count.
package shift_pkg;

    localparam logic [4:0] OP_SLL  = 5'b10001;
    localparam logic [4:0] OP_SRL  = 5'b10010;
    localparam logic [4:0] OP_SLLV = 5'b10011;
    localparam logic [4:0] OP_SRLV = 5'b10100;
    localparam logic [4:0] OP_SRA  = 5'b10101;
    localparam logic [4:0] OP_SRAV = 5'b10110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_shift_op(input logic [4:0] op);
        logic hit;
        hit = 1'b0;
        case (op)
            OP_SLL, OP_SRL, OP_SLLV, OP_SRLV, OP_SRA, OP_SRAV: hit = 1'b1;
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

    // Variable ops take the amount from a register, immediate ops from the
    // shamt field of the instruction.
    function automatic logic is_variable(input logic [4:0] op);
        return (op == OP_SLLV) || (op == OP_SRLV) || (op == OP_SRAV);
    endfunction

    function automatic logic is_arith(input logic [4:0] op);
        return (op == OP_SRA) || (op == OP_SRAV);
    endfunction

    function automatic logic is_left(input logic [4:0] op);
        return (op == OP_SLL) || (op == OP_SLLV);
    endfunction

    // Register amounts saturate at 32 so that huge shifts still clear (or
    // sign-fill) the whole word rather than wrapping modulo 32.
    function automatic logic [5:0] effective_amt(input logic [4:0] op,
                                                 input logic [31:0] amt);
        logic [5:0] eff;
        eff = 6'd0;
        if (!is_shift_op(op)) begin
            eff = 6'd0;
        end else if (is_variable(op)) begin
            eff = (amt > 32'd31) ? 6'd32 : amt[5:0];
        end else begin
            eff = {1'b0, amt[10:6]};
        end
        return eff;
    endfunction

endpackage

// File: rtl/shift_step.sv
// shift_step
// Combinational single-step shifter. Shifts a 32-bit value by 0..STEP_MAX
// positions in one direction, filling vacated bits with zero (left) or with
// the supplied fill bit (right).
// Ports:
//   value  - operand
//   amt    - step amount, $clog2(STEP_MAX)+1 bits; 0 passes value through
//   left   - 1 = shift left, 0 = shift right
//   fill   - bit shifted in from the top on right shifts
//   result - shifted value
module shift_step #(
    parameter int STEP_MAX = 8
) (
    input  logic [31:0]                  value,
    input  logic [$clog2(STEP_MAX):0]    amt,
    input  logic                         left,
    input  logic                         fill,
    output logic [31:0]                  result
);

    logic [31:0] fill_mask;

    // The fill mask marks the top amt bit positions; a full 32-bit step
    // yields an all-ones mask so arithmetic shifts by 32 replicate the sign.
    always_comb begin
        fill_mask = fill ? ~(32'hFFFF_FFFF >> amt) : 32'h0000_0000;
        result    = left ? (value << amt) : ((value >> amt) | fill_mask);
    end

endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer
// Multi-cycle shift controller. Accepts one request over valid/ready, decodes
// the shift ALUop and amount, then shifts at most STEP_MAX positions per cycle
// and holds the result until the consumer takes it.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   flush                 - synchronous abort back to IDLE
//   req_valid/req_ready   - request handshake (ready only in IDLE)
//   req_op, req_data, req_amt - ALUop, operand, amount source
//   res_valid/res_ready   - result handshake
//   res_data, res_err     - shifted value, invalid-op flag
//   busy                  - controller not in IDLE
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int STEP_MAX = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_op,
    input  logic [31:0] req_data,
    input  logic [31:0] req_amt,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        res_err,
    output logic        busy
);

    localparam int SW = $clog2(STEP_MAX) + 1;

    state_t        state_q, state_d;
    logic [31:0]   acc_q;
    logic [5:0]    rem_q;
    logic          left_q;
    logic          fill_q;
    logic          err_q;

    logic          accept;
    logic [SW-1:0] step;
    logic [5:0]    rem_after;
    logic [31:0]   step_out;

    assign accept = req_valid && (state_q == ST_IDLE) && !flush;

    // Each RUN cycle consumes min(rem, STEP_MAX) positions; rem == 0 yields a
    // zero step so an empty shift still spends one RUN cycle.
    always_comb begin
        step      = (rem_q < 6'(STEP_MAX)) ? rem_q[SW-1:0] : SW'(STEP_MAX);
        rem_after = rem_q - 6'(step);
    end

    shift_step #(
        .STEP_MAX (STEP_MAX)
    ) u_step (
        .value  (acc_q),
        .amt    (step),
        .left   (left_q),
        .fill   (fill_q),
        .result (step_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // flush overrides every other transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_RUN;
            ST_RUN:  if (rem_after == 6'd0) state_d = ST_DONE;
            ST_DONE: if (res_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (flush) begin
            state_d = ST_IDLE;
        end
    end

    // The fill bit is captured once at accept so every right-shift step of
    // SRA/SRAV uses the original sign, not the partially shifted acc[31].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= 32'h0;
            rem_q  <= 6'd0;
            left_q <= 1'b0;
            fill_q <= 1'b0;
            err_q  <= 1'b0;
        end else if (flush) begin
            rem_q <= 6'd0;
        end else if (accept) begin
            acc_q  <= req_data;
            rem_q  <= effective_amt(req_op, req_amt);
            left_q <= is_left(req_op);
            fill_q <= is_arith(req_op) && req_data[31];
            err_q  <= !is_shift_op(req_op);
        end else if (state_q == ST_RUN) begin
            acc_q <= step_out;
            rem_q <= rem_after;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign res_valid = (state_q == ST_DONE);
    assign res_data  = acc_q;
    assign res_err   = err_q;

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle controller for the KGP-miniRISC shift unit. It accepts one shift request at a time over a valid/ready handshake and decodes the shift ALUop and shift amount. It then performs the shift iteratively, at most STEP_MAX bit positions per cycle, through a small step datapath, and holds the result until the consumer takes it. It sits beside the ALU in the execute stage, so the single-cycle 32-bit barrel shifter can be replaced with a narrower one at the cost of variable latency.

## Interface
- STEP_MAX, default 8: maximum bit positions shifted per cycle; power of two, 1..32.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous abort; returns to IDLE and discards any in-flight or held result.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request (high only in IDLE).
- req_op  in  5  ALUop:
  - 10001 SLL, 10010 SRL, 10011 SLLV, 10100 SRLV, 10101 SRA, 10110 SRAV;
  - any other value is invalid.
- req_data  in  32  operand to shift.
- req_amt  in  32  immediate ops take the amount from req_amt[10:6]; variable ops use the full 32 bits.
- res_valid  out  1  result held.
- res_ready  in  1  consumer takes result.
- res_data  out  32  shifted value.
- res_err  out  1  request carried an invalid op.
- busy  out  1  state is not IDLE.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE:**
  - req_ready=1.
  - On req_valid&req_ready: latch operand into acc, latch direction (left/right) and fill mode (zero, or the latched req_data[31] for SRA/SRAV).
  - Load the remaining counter rem (6 bits) with the effective amount; go to RUN.
- **Effective amount:**
  - Immediate ops: req_amt[10:6] (0..31).
  - Variable ops: req_amt if req_amt<32, else 32 (saturating).
  - Amount 32 gives 0 for logical shifts and 32 copies of the sign for arithmetic shifts.
- **Invalid op:** accepted; rem=0, acc=req_data, err flag latched as 1.
- **RUN:** each cycle:
  - step = min(rem, STEP_MAX);
  - acc = acc shifted by step, filling with zero or sign;
  - rem = rem - step.
  - When rem-step==0 (including rem==0 on entry), go to DONE on the same edge.
- **DONE:** res_valid=1; res_data=acc and res_err=err, both stable. On res_ready go to IDLE.
- **flush:** has priority over every other transition from any state. Next state is IDLE, res_valid drops, and a request presented in the same cycle is not accepted.
- There is no overlap: a new request is never accepted in RUN or DONE. A back-to-back request is accepted in the cycle after the DONE→IDLE edge.
- Arithmetic right shifts at every step fill with the bit latched at accept, not the current acc[31].

## Timing
- **Reset values:** state=IDLE, req_ready=1, res_valid=0, res_data=0, res_err=0, busy=0, rem=0.
- **Latency:** N = max(1, ceil(amt/STEP_MAX)) clock edges from the accept edge to res_valid high.
  - With STEP_MAX=8: amt 0 → 1, 1..8 → 1, 9 → 2, 31 → 4, 32 → 4.
- **Throughput:** at most one result per N+2 cycles (accept, N run edges, DONE→IDLE).
- res_valid, res_data and res_err are registered; there are no combinational paths from req_* to res_*.
- req_ready depends only on state.
- res_valid stays high until res_ready is sampled high or flush is asserted.
- Reset asserted mid-RUN or mid-DONE clears immediately and asynchronously; the operation is lost.

## Structure
- Package shift_pkg holds:
  - localparams for the six shift ALUops (SLL…SRAV);
  - the FSM state enum;
  - an is_shift_op / is_variable / is_arith decode function.
- Sub-module shift_step (combinational):
  - inputs: 32-bit value, step amount ($clog2(STEP_MAX)+1 bits), direction, fill bit;
  - output: 32-bit value;
  - a step amount of 0 passes the value through.
- Top level holds the FSM, the rem counter, acc, and the handshake registers.

## Test plan
- Reset, then SLL with data=0x0000_0001, amt[10:6]=4 → after 1 cycle res_data=0x0000_0010, res_err=0; req_ready low during RUN/DONE.
- SRAV with data=0x8000_0000, amt=31, STEP_MAX=8 → res_valid exactly 4 edges after accept, res_data=0xFFFF_FFFF. The same request with amt=0x100 → 0xFFFF_FFFF. SRLV with amt=0x100 → 0x0000_0000.
- SRL with data=0xF000_000F, amt 0 → res_data=0xF000_000F after 1 cycle. Hold res_ready=0 for 5 cycles → res_valid and res_data stable throughout, no new accept.
- Invalid op 5'b00011 with data=0x1234_5678 → res_data=0x1234_5678, res_err=1.
- Assert flush in the second RUN cycle of SLLV amt=20 → next cycle IDLE, res_valid never rises. A following SLL amt 3 of 0x1 returns 0x8.
- Drop rst_n mid-RUN → outputs at reset values asynchronously. After release, a back-to-back stream of 3 requests with res_ready=1 completes in order, each accepted one cycle after the previous DONE.
